llc_set_engine: RTL and testbench

//  Parametrised N-way set-associative LLC tag/state engine: per set, holds tags, MESI states and tree-PLRU bits.

---
 rtl/llc_set_engine_if.sv | 51 +++++
 rtl/llc_set_engine.sv | 390 +++++++++++++++++++++++++++++++++++++++
 tb/tb_llc_set_engine.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/llc_set_engine_if.sv
`default_nettype none
// =============================================================================
// Module      : llc_set_engine_if
// Description : Request/response bundle between the command front end
//               (master) and the LLC set engine (slave).
//   req_valid / req_ready        : request handshake
//   req_op / req_addr            : operation code and byte address
//   req_snoop_in                 : other caches' result for our bus op
//   rsp_valid / rsp_ready        : response handshake
//   rsp_hit / rsp_way / rsp_mesi : lookup result and resulting line state
//   rsp_bus_op / rsp_wb          : bus operation issued, dirty writeback
//   rsp_victim_tag / rsp_l1_msg  : evicted tag, message towards L1
//   rsp_snoop                    : our own snoop result
// Revision    : 1.0 - initial release
// =============================================================================
interface llc_set_engine_if #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int WAYS          = 4,
   parameter int TAG_BITS      = 22
);
   localparam int WAY_BITS = $clog2(WAYS);

   logic                     req_valid;
   logic                     req_ready;
   logic [2:0]               req_op;
   logic [ADDRESS_WIDTH-1:0] req_addr;
   logic [1:0]               req_snoop_in;
   logic                     rsp_valid;
   logic                     rsp_ready;
   logic                     rsp_hit;
   logic [WAY_BITS-1:0]      rsp_way;
   logic [1:0]               rsp_mesi;
   logic [2:0]               rsp_bus_op;
   logic                     rsp_wb;
   logic [TAG_BITS-1:0]      rsp_victim_tag;
   logic [2:0]               rsp_l1_msg;
   logic [1:0]               rsp_snoop;

   modport master (
      output req_valid, req_op, req_addr, req_snoop_in, rsp_ready,
      input  req_ready, rsp_valid, rsp_hit, rsp_way, rsp_mesi, rsp_bus_op,
             rsp_wb, rsp_victim_tag, rsp_l1_msg, rsp_snoop
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_snoop_in, rsp_ready,
      output req_ready, rsp_valid, rsp_hit, rsp_way, rsp_mesi, rsp_bus_op,
             rsp_wb, rsp_victim_tag, rsp_l1_msg, rsp_snoop
   );
endinterface
`default_nettype wire

// File: rtl/llc_set_engine.sv
`default_nettype none
// =============================================================================
// Module      : llc_set_engine
// Description : N-way set-associative LLC tag/state engine. Per set it holds
//               tags, MESI states and tree-PLRU bits, and serves one CPU or
//               snooped request at a time.
//   clk  : clock
//   rst  : asynchronous active-high reset (restarts the array sweep)
//   bus  : llc_set_engine_if.slave - request handshake in, response out
// Revision    : 1.0 - initial release
// =============================================================================
module llc_set_engine #(
   parameter int SETS          = 16,
   parameter int WAYS          = 4,
   parameter int ADDRESS_WIDTH = 32,
   parameter int LINE_BYTES    = 64
) (
   input wire              clk,
   input wire              rst,
   llc_set_engine_if.slave bus
);
   localparam int INDEX_BITS  = $clog2(SETS);
   localparam int OFFSET_BITS = $clog2(LINE_BYTES);
   localparam int TAG_BITS    = ADDRESS_WIDTH - INDEX_BITS - OFFSET_BITS;
   localparam int WAY_BITS    = $clog2(WAYS);

   localparam logic [2:0] c_op_cpu_rd   = 3'd0;
   localparam logic [2:0] c_op_cpu_wr   = 3'd1;
   localparam logic [2:0] c_op_snp_rd   = 3'd2;
   localparam logic [2:0] c_op_snp_wr   = 3'd3;
   localparam logic [2:0] c_op_snp_rwim = 3'd4;
   localparam logic [2:0] c_op_snp_inv  = 3'd5;
   localparam logic [2:0] c_op_clear    = 3'd6;
   localparam logic [2:0] c_op_nop      = 3'd7;

   localparam logic [1:0] c_mesi_i = 2'b00;
   localparam logic [1:0] c_mesi_e = 2'b01;
   localparam logic [1:0] c_mesi_m = 2'b10;
   localparam logic [1:0] c_mesi_s = 2'b11;

   localparam logic [1:0] c_snp_hit   = 2'b00;
   localparam logic [1:0] c_snp_hitm  = 2'b01;
   localparam logic [1:0] c_snp_nohit = 2'b10;
   localparam logic [1:0] c_snp_none  = 2'b11;

   localparam logic [2:0] c_bus_none  = 3'd0;
   localparam logic [2:0] c_bus_read  = 3'd1;
   localparam logic [2:0] c_bus_inval = 3'd3;
   localparam logic [2:0] c_bus_rwim  = 3'd4;

   localparam logic [2:0] c_l1_none    = 3'd0;
   localparam logic [2:0] c_l1_getline = 3'd1;
   localparam logic [2:0] c_l1_sendln  = 3'd2;
   localparam logic [2:0] c_l1_invln   = 3'd3;
   localparam logic [2:0] c_l1_evict   = 3'd4;

   localparam logic [INDEX_BITS-1:0] c_last_set  = INDEX_BITS'(SETS - 1);
   localparam logic [WAYS-2:0]       c_plru_one  = (WAYS-1)'(1);

   typedef enum logic [2:0] {
      S_INIT   = 3'd0,
      S_IDLE   = 3'd1,
      S_LOOKUP = 3'd2,
      S_UPDATE = 3'd3,
      S_RESP   = 3'd4,
      S_CLEAR  = 3'd5
   } state_t;

   // ---------------------------------------------------------------- storage
   logic [TAG_BITS-1:0] r_tag_mem  [SETS][WAYS];
   logic [1:0]          r_mesi_mem [SETS][WAYS];
   logic [WAYS-2:0]     r_plru_mem [SETS];

   // ---------------------------------------------------------------- state
   state_t                r_state;
   logic [INDEX_BITS-1:0] r_cnt;
   logic                  r_req_ready;
   logic [2:0]            r_op;
   logic [TAG_BITS-1:0]   r_req_tag;
   logic [INDEX_BITS-1:0] r_req_set;
   logic [1:0]            r_snoop_in;
   logic [TAG_BITS-1:0]   r_rd_tag  [WAYS];
   logic [1:0]            r_rd_mesi [WAYS];
   logic [WAYS-2:0]       r_rd_plru;

   logic                  r_rsp_valid;
   logic                  r_rsp_hit;
   logic [WAY_BITS-1:0]   r_rsp_way;
   logic [1:0]            r_rsp_mesi;
   logic [2:0]            r_rsp_bus_op;
   logic                  r_rsp_wb;
   logic [TAG_BITS-1:0]   r_rsp_victim_tag;
   logic [2:0]            r_rsp_l1_msg;
   logic [1:0]            r_rsp_snoop;

   // ---------------------------------------------------------------- update logic
   logic                  w_hit;
   logic [WAY_BITS-1:0]   w_hit_way;
   logic [WAY_BITS-1:0]   w_victim;
   logic [WAY_BITS-1:0]   w_way;
   logic [WAYS-2:0]       w_new_plru;
   logic [1:0]            w_cur_mesi;
   logic [1:0]            w_vic_mesi;
   logic [1:0]            w_new_mesi;
   logic [2:0]            w_bus_op;
   logic                  w_wb;
   logic [TAG_BITS-1:0]   w_victim_tag;
   logic [2:0]            w_l1_msg;
   logic [1:0]            w_snoop;
   logic                  w_mem_we;
   logic                  w_plru_we;
   logic                  w_sweep;

   assign w_sweep = (r_state == S_INIT) || (r_state == S_CLEAR);

   // Tag compare; at most one valid way can match, lowest index wins anyway.
   always_comb begin : p_hit
      w_hit     = 1'b0;
      w_hit_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if ((r_rd_mesi[w] != c_mesi_i) && (r_rd_tag[w] == r_req_tag)) begin
            w_hit     = 1'b1;
            w_hit_way = WAY_BITS'(w);
         end
      end
   end

   // Victim: lowest invalid way, else walk the PLRU tree from the root.
   always_comb begin : p_victim
      int              node;
      logic            has_inv;
      logic [WAYS-2:0] sh;
      has_inv  = 1'b0;
      w_victim = '0;
      node     = 0;
      sh       = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (r_rd_mesi[w] == c_mesi_i) begin
            has_inv  = 1'b1;
            w_victim = WAY_BITS'(w);
         end
      end
      for (int l = 0; l < WAY_BITS; l++) begin
         sh   = r_rd_plru >> node;
         node = 2 * node + 1 + int'(sh[0]);
      end
      if (!has_inv) begin
         w_victim = WAY_BITS'(node - (WAYS - 1));
      end
   end

   assign w_way = w_hit ? w_hit_way : w_victim;

   // Each node on the path to the accessed way is pointed away from it.
   always_comb begin : p_plru
      int                  node;
      logic [WAY_BITS-1:0] sh;
      logic [WAYS-2:0]     mask;
      w_new_plru = r_rd_plru;
      node       = 0;
      sh         = '0;
      mask       = '0;
      for (int l = 0; l < WAY_BITS; l++) begin
         sh   = w_way >> (WAY_BITS - 1 - l);
         mask = c_plru_one << node;
         if (sh[0]) begin
            w_new_plru = w_new_plru & ~mask;
         end else begin
            w_new_plru = w_new_plru | mask;
         end
         node = 2 * node + 1 + int'(sh[0]);
      end
   end

   assign w_cur_mesi = w_hit ? r_rd_mesi[w_hit_way] : c_mesi_i;
   assign w_vic_mesi = r_rd_mesi[w_victim];

   always_comb begin : p_decode
      w_new_mesi   = w_cur_mesi;
      w_bus_op     = c_bus_none;
      w_wb         = 1'b0;
      w_victim_tag = '0;
      w_l1_msg     = c_l1_none;
      w_snoop      = c_snp_none;
      w_mem_we     = 1'b0;
      w_plru_we    = 1'b0;
      case (r_op)
         c_op_cpu_rd, c_op_cpu_wr: begin
            w_mem_we  = 1'b1;
            w_plru_we = 1'b1;
            w_l1_msg  = c_l1_sendln;
            if (w_hit) begin
               if (r_op == c_op_cpu_wr) begin
                  w_new_mesi = c_mesi_m;
                  // A shared copy must kill the other caches' copies first.
                  if (w_cur_mesi == c_mesi_s) begin
                     w_bus_op = c_bus_inval;
                  end
               end
            end else begin
               if (r_op == c_op_cpu_wr) begin
                  w_bus_op   = c_bus_rwim;
                  w_new_mesi = c_mesi_m;
               end else begin
                  w_bus_op   = c_bus_read;
                  w_new_mesi = r_snoop_in[1] ? c_mesi_e : c_mesi_s;
               end
               // Dirty victim writeback is implied; bus_op still reports the fill.
               if (w_vic_mesi != c_mesi_i) begin
                  w_l1_msg     = c_l1_evict;
                  w_victim_tag = r_rd_tag[w_victim];
                  w_wb         = (w_vic_mesi == c_mesi_m);
               end
            end
         end
         c_op_snp_rd: begin
            w_snoop = c_snp_nohit;
            if (w_hit) begin
               w_mem_we   = 1'b1;
               w_new_mesi = c_mesi_s;
               if (w_cur_mesi == c_mesi_m) begin
                  w_snoop  = c_snp_hitm;
                  w_wb     = 1'b1;
                  w_l1_msg = c_l1_getline;
               end else begin
                  w_snoop  = c_snp_hit;
               end
            end
         end
         c_op_snp_wr: begin
            w_snoop = c_snp_nohit;
         end
         c_op_snp_rwim: begin
            w_snoop = c_snp_nohit;
            if (w_hit) begin
               w_mem_we   = 1'b1;
               w_new_mesi = c_mesi_i;
               if (w_cur_mesi == c_mesi_m) begin
                  w_snoop  = c_snp_hitm;
                  w_wb     = 1'b1;
                  w_l1_msg = c_l1_evict;
               end else begin
                  w_snoop  = c_snp_hit;
                  w_l1_msg = c_l1_invln;
               end
            end
         end
         c_op_snp_inv: begin
            w_snoop = c_snp_nohit;
            if (w_hit && (w_cur_mesi == c_mesi_s)) begin
               w_mem_we   = 1'b1;
               w_new_mesi = c_mesi_i;
               w_snoop    = c_snp_hit;
               w_l1_msg   = c_l1_invln;
            end
         end
         default: begin
         end
      endcase
   end

   // ---------------------------------------------------------------- array write port
   // No reset on the arrays: the INIT sweep after reset invalidates every way.
   always_ff @(posedge clk) begin
      if (w_sweep) begin
         for (int w = 0; w < WAYS; w++) begin
            r_mesi_mem[r_cnt][w] <= c_mesi_i;
         end
         r_plru_mem[r_cnt] <= '0;
      end else if ((r_state == S_UPDATE) && w_mem_we) begin
         r_tag_mem[r_req_set][w_way]  <= r_req_tag;
         r_mesi_mem[r_req_set][w_way] <= w_new_mesi;
         if (w_plru_we) begin
            r_plru_mem[r_req_set] <= w_new_plru;
         end
      end
   end

   // ---------------------------------------------------------------- control FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state          <= S_INIT;
         r_cnt            <= '0;
         r_req_ready      <= 1'b0;
         r_op             <= c_op_nop;
         r_req_tag        <= '0;
         r_req_set        <= '0;
         r_snoop_in       <= '0;
         for (int w = 0; w < WAYS; w++) begin
            r_rd_tag[w]  <= '0;
            r_rd_mesi[w] <= c_mesi_i;
         end
         r_rd_plru        <= '0;
         r_rsp_valid      <= 1'b0;
         r_rsp_hit        <= 1'b0;
         r_rsp_way        <= '0;
         r_rsp_mesi       <= c_mesi_i;
         r_rsp_bus_op     <= c_bus_none;
         r_rsp_wb         <= 1'b0;
         r_rsp_victim_tag <= '0;
         r_rsp_l1_msg     <= c_l1_none;
         r_rsp_snoop      <= c_snp_none;
      end else begin
         case (r_state)
            S_INIT: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == c_last_set) begin
                  r_state     <= S_IDLE;
                  r_req_ready <= 1'b1;
               end
            end
            S_IDLE: begin
               if (bus.req_valid && r_req_ready) begin
                  r_req_ready      <= 1'b0;
                  r_op             <= bus.req_op;
                  r_req_tag        <= bus.req_addr[ADDRESS_WIDTH-1 -: TAG_BITS];
                  r_req_set        <= bus.req_addr[OFFSET_BITS +: INDEX_BITS];
                  r_snoop_in       <= bus.req_snoop_in;
                  // Clear and nop respond with these idle values.
                  r_rsp_hit        <= 1'b0;
                  r_rsp_way        <= '0;
                  r_rsp_mesi       <= c_mesi_i;
                  r_rsp_bus_op     <= c_bus_none;
                  r_rsp_wb         <= 1'b0;
                  r_rsp_victim_tag <= '0;
                  r_rsp_l1_msg     <= c_l1_none;
                  r_rsp_snoop      <= c_snp_none;
                  case (bus.req_op)
                     c_op_clear: r_state <= S_CLEAR;
                     c_op_nop:   r_state <= S_RESP;
                     default:    r_state <= S_LOOKUP;
                  endcase
               end
            end
            S_LOOKUP: begin
               for (int w = 0; w < WAYS; w++) begin
                  r_rd_tag[w]  <= r_tag_mem[r_req_set][w];
                  r_rd_mesi[w] <= r_mesi_mem[r_req_set][w];
               end
               r_rd_plru <= r_plru_mem[r_req_set];
               r_state   <= S_UPDATE;
            end
            S_UPDATE: begin
               r_rsp_hit        <= w_hit;
               r_rsp_way        <= w_way;
               r_rsp_mesi       <= w_new_mesi;
               r_rsp_bus_op     <= w_bus_op;
               r_rsp_wb         <= w_wb;
               r_rsp_victim_tag <= w_victim_tag;
               r_rsp_l1_msg     <= w_l1_msg;
               r_rsp_snoop      <= w_snoop;
               r_state          <= S_RESP;
            end
            S_RESP: begin
               // rsp_valid rises one cycle after entry, then holds until taken.
               if (!r_rsp_valid) begin
                  r_rsp_valid <= 1'b1;
               end else if (bus.rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_req_ready <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            S_CLEAR: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == c_last_set) begin
                  r_state <= S_RESP;
               end
            end
            default: begin
               r_state <= S_INIT;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign bus.req_ready      = r_req_ready;
   assign bus.rsp_valid      = r_rsp_valid;
   assign bus.rsp_hit        = r_rsp_hit;
   assign bus.rsp_way        = r_rsp_way;
   assign bus.rsp_mesi       = r_rsp_mesi;
   assign bus.rsp_bus_op     = r_rsp_bus_op;
   assign bus.rsp_wb         = r_rsp_wb;
   assign bus.rsp_victim_tag = r_rsp_victim_tag;
   assign bus.rsp_l1_msg     = r_rsp_l1_msg;
   assign bus.rsp_snoop      = r_rsp_snoop;

endmodule
`default_nettype wire

// File: tb/tb_llc_set_engine.sv
`default_nettype none
// =============================================================================
// Module      : tb_llc_set_engine
// Description : Directed self-checking bench for llc_set_engine
//               (SETS=16, WAYS=4, 32-bit addresses, 64-byte lines).
// Revision    : 1.0 - initial release
// =============================================================================
module tb_llc_set_engine;
   localparam int SETS = 16;
   localparam int WAYS = 4;
   localparam int AW   = 32;
   localparam int TAGB = 22;

   logic clk;
   logic rst;
   int   n_pass;
   int   n_total;
   int   lat;

   llc_set_engine_if #(.ADDRESS_WIDTH(AW), .WAYS(WAYS), .TAG_BITS(TAGB)) bus_if ();

   llc_set_engine #(.SETS(SETS), .WAYS(WAYS), .ADDRESS_WIDTH(AW), .LINE_BYTES(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one request; leaves rsp_valid high (or reports a timeout).
   task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [1:0] snp);
      int n;
      n = 0;
      while (bus_if.req_ready !== 1'b1 && n < 200) begin
         @(posedge clk); #1; n++;
      end
      if (bus_if.req_ready !== 1'b1) begin
         n_total++;
         $display("FAIL req_ready_timeout: req_ready=%0b expected 1", bus_if.req_ready);
      end
      bus_if.req_valid    = 1'b1;
      bus_if.req_op       = op;
      bus_if.req_addr     = addr;
      bus_if.req_snoop_in = snp;
      @(posedge clk); #1;
      bus_if.req_valid = 1'b0;
      lat = 0;
      while (bus_if.rsp_valid !== 1'b1 && lat < 200) begin
         @(posedge clk); #1; lat++;
      end
      if (bus_if.rsp_valid !== 1'b1) begin
         n_total++;
         $display("FAIL rsp_timeout: rsp_valid=%0b expected 1", bus_if.rsp_valid);
      end
   endtask

   task automatic take_rsp();
      bus_if.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus_if.rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      int cnt;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_total++;
      if (bus_if.rsp_valid !== 1'b0 || bus_if.req_ready !== 1'b0)
         $display("FAIL reset_handshake: valid=%0b ready=%0b expected 0 0", bus_if.rsp_valid, bus_if.req_ready);
      else n_pass++;
      n_total++;
      if ({bus_if.rsp_hit, bus_if.rsp_mesi, bus_if.rsp_bus_op, bus_if.rsp_wb, bus_if.rsp_l1_msg, bus_if.rsp_snoop} !== 12'b0_00_000_0_000_11)
         $display("FAIL reset_fields: hit=%0b mesi=%0b bus=%0d wb=%0b l1=%0d snoop=%0b expected 0 00 0 0 0 11",
                  bus_if.rsp_hit, bus_if.rsp_mesi, bus_if.rsp_bus_op, bus_if.rsp_wb, bus_if.rsp_l1_msg, bus_if.rsp_snoop);
      else n_pass++;
      rst = 1'b0;
      cnt = 0;
      while (bus_if.req_ready !== 1'b1 && cnt < 100) begin
         @(posedge clk); #1; cnt++;
      end
      n_total++;
      if (cnt != SETS) $display("FAIL init_sweep_cycles: got %0d expected %0d", cnt, SETS);
      else n_pass++;
   endtask

   task automatic test_read_miss();
      issue(3'd0, 32'h0000_0040, 2'b10);
      n_total++;
      if (lat != 3) $display("FAIL read_miss_latency: got %0d expected 3", lat);
      else n_pass++;
      n_total++;
      if (bus_if.rsp_hit !== 1'b0 || bus_if.rsp_way !== 2'd0 || bus_if.rsp_mesi !== 2'b01)
         $display("FAIL read_miss_state: hit=%0b way=%0d mesi=%0b expected 0 0 01", bus_if.rsp_hit, bus_if.rsp_way, bus_if.rsp_mesi);
      else n_pass++;
      n_total++;
      if (bus_if.rsp_bus_op !== 3'd1 || bus_if.rsp_l1_msg !== 3'd2 || bus_if.rsp_wb !== 1'b0 || bus_if.rsp_snoop !== 2'b11)
         $display("FAIL read_miss_msgs: bus=%0d l1=%0d wb=%0b snoop=%0b expected 1 2 0 11",
                  bus_if.rsp_bus_op, bus_if.rsp_l1_msg, bus_if.rsp_wb, bus_if.rsp_snoop);
      else n_pass++;
      take_rsp();
   endtask

   task automatic test_write_hit();
      issue(3'd1, 32'h0000_0040, 2'b10);
      n_total++;
      if (bus_if.rsp_hit !== 1'b1 || bus_if.rsp_mesi !== 2'b10 || bus_if.rsp_bus_op !== 3'd0 || bus_if.rsp_l1_msg !== 3'd2)
         $display("FAIL write_hit_e: hit=%0b mesi=%0b bus=%0d l1=%0d expected 1 10 0 2",
                  bus_if.rsp_hit, bus_if.rsp_mesi, bus_if.rsp_bus_op, bus_if.rsp_l1_msg);
      else n_pass++;
      take_rsp();
   endtask

   task automatic test_snoop_read();
      issue(3'd2, 32'h0000_0040, 2'b10);
      n_total++;
      if (bus_if.rsp_snoop !== 2'b01 || bus_if.rsp_wb !== 1'b1 || bus_if.rsp_l1_msg !== 3'd1 || bus_if.rsp_mesi !== 2'b11)
         $display("FAIL snoop_read_m: snoop=%0b wb=%0b l1=%0d mesi=%0b expected 01 1 1 11",
                  bus_if.rsp_snoop, bus_if.rsp_wb, bus_if.rsp_l1_msg, bus_if.rsp_mesi);
      else n_pass++;
      take_rsp();
      issue(3'd1, 32'h0000_0040, 2'b10);
      n_total++;
      if (bus_if.rsp_hit !== 1'b1 || bus_if.rsp_bus_op !== 3'd3 || bus_if.rsp_mesi !== 2'b10)
         $display("FAIL write_hit_s: hit=%0b bus=%0d mesi=%0b expected 1 3 10", bus_if.rsp_hit, bus_if.rsp_bus_op, bus_if.rsp_mesi);
      else n_pass++;
      take_rsp();
   endtask

   task automatic test_back_to_back();
      n_total++;
      if (bus_if.req_ready !== 1'b1 || bus_if.rsp_valid !== 1'b0)
         $display("FAIL after_handshake: ready=%0b valid=%0b expected 1 0", bus_if.req_ready, bus_if.rsp_valid);
      else n_pass++;
      issue(3'd3, 32'h0000_0040, 2'b10);
      n_total++;
      if (lat != 3 || bus_if.rsp_snoop !== 2'b10 || bus_if.rsp_mesi !== 2'b10 || bus_if.rsp_hit !== 1'b1)
         $display("FAIL snoop_write: lat=%0d snoop=%0b mesi=%0b hit=%0b expected 3 10 10 1",
                  lat, bus_if.rsp_snoop, bus_if.rsp_mesi, bus_if.rsp_hit);
      else n_pass++;
      take_rsp();
   endtask

   task automatic test_snoop_inval();
      issue(3'd4, 32'h0000_0040, 2'b10);
      n_total++;
      if (bus_if.rsp_snoop !== 2'b01 || bus_if.rsp_wb !== 1'b1 || bus_if.rsp_l1_msg !== 3'd4 || bus_if.rsp_mesi !== 2'b00)
         $display("FAIL snoop_rwim_m: snoop=%0b wb=%0b l1=%0d mesi=%0b expected 01 1 4 00",
                  bus_if.rsp_snoop, bus_if.rsp_wb, bus_if.rsp_l1_msg, bus_if.rsp_mesi);
      else n_pass++;
      take_rsp();
      issue(3'd0, 32'h0000_0040, 2'b00);
      n_total++;
      if (bus_if.rsp_hit !== 1'b0 || bus_if.rsp_mesi !== 2'b11 || bus_if.rsp_l1_msg !== 3'd2)
         $display("FAIL read_miss_shared: hit=%0b mesi=%0b l1=%0d expected 0 11 2", bus_if.rsp_hit, bus_if.rsp_mesi, bus_if.rsp_l1_msg);
      else n_pass++;
      take_rsp();
      issue(3'd5, 32'h0000_0040, 2'b10);
      n_total++;
      if (bus_if.rsp_snoop !== 2'b00 || bus_if.rsp_l1_msg !== 3'd3 || bus_if.rsp_mesi !== 2'b00)
         $display("FAIL snoop_inv_s: snoop=%0b l1=%0d mesi=%0b expected 00 3 00", bus_if.rsp_snoop, bus_if.rsp_l1_msg, bus_if.rsp_mesi);
      else n_pass++;
      take_rsp();
      issue(3'd5, 32'h0000_0040, 2'b10);
      n_total++;
      if (bus_if.rsp_snoop !== 2'b10 || bus_if.rsp_l1_msg !== 3'd0 || bus_if.rsp_hit !== 1'b0)
         $display("FAIL snoop_inv_miss: snoop=%0b l1=%0d hit=%0b expected 10 0 0", bus_if.rsp_snoop, bus_if.rsp_l1_msg, bus_if.rsp_hit);
      else n_pass++;
      take_rsp();
   endtask

   task automatic test_plru_evict();
      logic [31:0] a;
      for (int t = 0; t < WAYS; t++) begin
         a = t << 10;
         issue(3'd0, a, 2'b10);
         n_total++;
         if (bus_if.rsp_hit !== 1'b0 || bus_if.rsp_way !== 2'(t))
            $display("FAIL fill_set0_t%0d: hit=%0b way=%0d expected 0 %0d", t, bus_if.rsp_hit, bus_if.rsp_way, t);
         else n_pass++;
         take_rsp();
      end
      issue(3'd0, 32'h0000_0000, 2'b10);
      n_total++;
      if (bus_if.rsp_hit !== 1'b1 || bus_if.rsp_way !== 2'd0)
         $display("FAIL reread_tag0: hit=%0b way=%0d expected 1 0", bus_if.rsp_hit, bus_if.rsp_way);
      else n_pass++;
      take_rsp();
      issue(3'd0, 32'h0000_1000, 2'b10);
      n_total++;
      if (bus_if.rsp_hit !== 1'b0 || bus_if.rsp_way !== 2'd2 || bus_if.rsp_l1_msg !== 3'd4 ||
          bus_if.rsp_victim_tag !== 22'd2 || bus_if.rsp_wb !== 1'b0 || bus_if.rsp_bus_op !== 3'd1)
         $display("FAIL plru_victim: hit=%0b way=%0d l1=%0d vtag=%0d wb=%0b bus=%0d expected 0 2 4 2 0 1",
                  bus_if.rsp_hit, bus_if.rsp_way, bus_if.rsp_l1_msg, bus_if.rsp_victim_tag, bus_if.rsp_wb, bus_if.rsp_bus_op);
      else n_pass++;
      take_rsp();
   endtask

   task automatic test_dirty_evict();
      logic [31:0] a;
      for (int t = 0; t < WAYS; t++) begin
         a = (t << 10) | 32'h80;
         issue(3'd1, a, 2'b10);
         n_total++;
         if (bus_if.rsp_way !== 2'(t) || bus_if.rsp_bus_op !== 3'd4 || bus_if.rsp_mesi !== 2'b10)
            $display("FAIL write_fill_t%0d: way=%0d bus=%0d mesi=%0b expected %0d 4 10", t, bus_if.rsp_way, bus_if.rsp_bus_op, bus_if.rsp_mesi, t);
         else n_pass++;
         take_rsp();
      end
      issue(3'd1, 32'h0000_1080, 2'b10);
      n_total++;
      if (bus_if.rsp_way !== 2'd0 || bus_if.rsp_l1_msg !== 3'd4 || bus_if.rsp_victim_tag !== 22'd0 ||
          bus_if.rsp_wb !== 1'b1 || bus_if.rsp_bus_op !== 3'd4)
         $display("FAIL dirty_victim: way=%0d l1=%0d vtag=%0d wb=%0b bus=%0d expected 0 4 0 1 4",
                  bus_if.rsp_way, bus_if.rsp_l1_msg, bus_if.rsp_victim_tag, bus_if.rsp_wb, bus_if.rsp_bus_op);
      else n_pass++;
      take_rsp();
   endtask

   task automatic test_hold();
      int bad;
      issue(3'd0, 32'h0000_0040, 2'b10);
      bad = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (bus_if.rsp_valid !== 1'b1 || bus_if.req_ready !== 1'b0 || bus_if.rsp_hit !== 1'b0 ||
             bus_if.rsp_way !== 2'd0 || bus_if.rsp_mesi !== 2'b01 || bus_if.rsp_bus_op !== 3'd1 ||
             bus_if.rsp_l1_msg !== 3'd2)
            bad++;
      end
      n_total++;
      if (bad != 0) $display("FAIL hold_stable: %0d bad cycles, expected 0", bad);
      else n_pass++;
      take_rsp();
   endtask

   task automatic test_clear();
      issue(3'd6, 32'h0, 2'b10);
      n_total++;
      if (lat != SETS + 1) $display("FAIL clear_latency: got %0d expected %0d", lat, SETS + 1);
      else n_pass++;
      n_total++;
      if ({bus_if.rsp_hit, bus_if.rsp_way, bus_if.rsp_mesi, bus_if.rsp_bus_op, bus_if.rsp_wb, bus_if.rsp_l1_msg, bus_if.rsp_snoop} !== 14'b0_00_00_000_0_000_11)
         $display("FAIL clear_fields: hit=%0b way=%0d mesi=%0b bus=%0d wb=%0b l1=%0d snoop=%0b expected 0 0 00 0 0 0 11",
                  bus_if.rsp_hit, bus_if.rsp_way, bus_if.rsp_mesi, bus_if.rsp_bus_op, bus_if.rsp_wb, bus_if.rsp_l1_msg, bus_if.rsp_snoop);
      else n_pass++;
      take_rsp();
      issue(3'd0, 32'h0000_0040, 2'b10);
      n_total++;
      if (bus_if.rsp_hit !== 1'b0) $display("FAIL clear_set1: hit=%0b expected 0", bus_if.rsp_hit);
      else n_pass++;
      take_rsp();
      issue(3'd0, 32'h0000_1000, 2'b10);
      n_total++;
      if (bus_if.rsp_hit !== 1'b0 || bus_if.rsp_way !== 2'd0 || bus_if.rsp_l1_msg !== 3'd2)
         $display("FAIL clear_set0: hit=%0b way=%0d l1=%0d expected 0 0 2", bus_if.rsp_hit, bus_if.rsp_way, bus_if.rsp_l1_msg);
      else n_pass++;
      take_rsp();
      issue(3'd0, 32'h0000_0480, 2'b10);
      n_total++;
      if (bus_if.rsp_hit !== 1'b0) $display("FAIL clear_set2: hit=%0b expected 0", bus_if.rsp_hit);
      else n_pass++;
      take_rsp();
   endtask

   task automatic test_reset_mid();
      int cnt;
      int seen;
      bus_if.req_valid    = 1'b1;
      bus_if.req_op       = 3'd0;
      bus_if.req_addr     = 32'h0000_0040;
      bus_if.req_snoop_in = 2'b10;
      @(posedge clk); #1;
      bus_if.req_valid = 1'b0;
      rst = 1'b1;
      #1;
      n_total++;
      if (bus_if.rsp_valid !== 1'b0 || bus_if.req_ready !== 1'b0)
         $display("FAIL mid_reset: valid=%0b ready=%0b expected 0 0", bus_if.rsp_valid, bus_if.req_ready);
      else n_pass++;
      @(posedge clk); #1;
      rst  = 1'b0;
      cnt  = 0;
      seen = 0;
      while (bus_if.req_ready !== 1'b1 && cnt < 100) begin
         @(posedge clk); #1; cnt++;
         if (bus_if.rsp_valid !== 1'b0) seen++;
      end
      n_total++;
      if (cnt != SETS || seen != 0)
         $display("FAIL mid_reset_sweep: cycles=%0d stray_rsp=%0d expected %0d 0", cnt, seen, SETS);
      else n_pass++;
      issue(3'd0, 32'h0000_0040, 2'b10);
      n_total++;
      if (bus_if.rsp_hit !== 1'b0) $display("FAIL mid_reset_lines: hit=%0b expected 0", bus_if.rsp_hit);
      else n_pass++;
      take_rsp();
   endtask

   initial begin
      n_pass              = 0;
      n_total             = 0;
      lat                 = 0;
      rst                 = 1'b1;
      bus_if.req_valid    = 1'b0;
      bus_if.req_op       = 3'd7;
      bus_if.req_addr     = '0;
      bus_if.req_snoop_in = 2'b10;
      bus_if.rsp_ready    = 1'b0;
      test_reset();
      test_read_miss();
      test_write_hit();
      test_snoop_read();
      test_back_to_back();
      test_snoop_inval();
      test_plru_evict();
      test_dirty_evict();
      test_hold();
      test_clear();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
`default_nettype wire
